// File: rtl/cond_branch_sequencer.sv
// cond_branch_sequencer: holds branch requests until pending ALU flag writers retire, then resolves the condition
module cond_branch_sequencer #(
  parameter int PEND_W = 2,
  parameter int TGT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag_issue,
  output logic             flag_issue_ready,
  input  logic             alu_done,
  input  logic             alu_setflags,
  input  logic             alu_sel_sum,
  input  logic             alu_zero,
  input  logic             alu_msb,
  input  logic             alu_carry,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             a_lsb,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [4:0]       br_cond,
  input  logic [TGT_W-1:0] br_target,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_taken,
  output logic [TGT_W-1:0] res_target,
  input  logic             flush
);
  typedef enum logic [1:0] {IDLE, WAIT, EVAL, RESP} state_t;
  state_t            r_state;
  logic [PEND_W-1:0] r_pend;
  logic              r_z, r_n, r_v, r_c, r_a0;
  logic [4:0]        r_cond;
  logic [TGT_W-1:0]  r_target;
  logic              r_taken, r_valid;
  logic              w_ret, w_dec, w_inc, w_v, w_base;
  assign w_ret = alu_done & alu_setflags;
  assign w_dec = w_ret & (r_pend != '0);
  // An issue arriving while full still lands if a retire frees a slot in the same cycle.
  assign w_inc = flag_issue & (flag_issue_ready | w_dec);
  assign w_v = alu_sel_sum & ((a_msb & b_msb & ~alu_msb) | (~a_msb & ~b_msb & alu_msb));
  assign flag_issue_ready = r_pend != '1;
  assign br_ready = r_state == IDLE;
  assign res_valid = r_valid;
  assign res_taken = r_taken;
  assign res_target = r_target;
  // Base condition term selected by the low four condition bits.
  always_comb begin
    w_base = 1'b0;
    case (r_cond[3:0])
      4'd0: w_base = 1'b1;
      4'd1: w_base = r_z;
      4'd2: w_base = r_n;
      4'd3: w_base = r_v;
      4'd4: w_base = r_c;
      4'd5: w_base = r_n ^ r_v;
      4'd6: w_base = r_z | (r_n ^ r_v);
      4'd7: w_base = ~r_c | r_z;
      4'd8: w_base = r_a0;
      default: w_base = 1'b0;
    endcase
  end
  // Pending flag-writer count and the architectural flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
      {r_z, r_n, r_v, r_c, r_a0} <= '0;
    end else begin
      if (w_inc & ~w_dec) r_pend <= r_pend + 1'b1;
      else if (w_dec & ~w_inc) r_pend <= r_pend - 1'b1;
      if (w_ret) {r_z, r_n, r_v, r_c, r_a0} <= {alu_zero, alu_msb, w_v, alu_carry, a_lsb};
    end
  end
  // Branch sequencing: accept, wait for flags to settle, evaluate, hand back the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cond <= '0;
      r_target <= '0;
      r_taken <= 1'b0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (br_valid) begin
          r_cond <= br_cond;
          r_target <= br_target;
          r_state <= (r_pend == '0) ? EVAL : WAIT;
        end
        WAIT: if (r_pend == '0) r_state <= EVAL;
        EVAL: begin
          r_taken <= w_base ^ r_cond[4];
          r_valid <= 1'b1;
          r_state <= RESP;
        end
        RESP: if (res_ready) begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cond_branch_sequencer.sv
// tb_cond_branch_sequencer: directed plus random stimulus checked against a cycle-level behavioural model
module tb_cond_branch_sequencer;
  localparam int MAXC = 3;
  logic clk = 0, rst = 1;
  logic flag_issue = 0, flag_issue_ready;
  logic alu_done = 0, alu_setflags = 0, alu_sel_sum = 0, alu_zero = 0, alu_msb = 0, alu_carry = 0;
  logic a_msb = 0, b_msb = 0, a_lsb = 0;
  logic br_valid = 0, br_ready;
  logic [4:0] br_cond = 0;
  logic [15:0] br_target = 0;
  logic res_valid, res_ready = 0, res_taken;
  logic [15:0] res_target;
  logic flush = 0;
  int n_chk = 0, n_err = 0, cyc = 0;
  bit armed = 0;
  int m_cnt, m_due;
  bit m_z, m_n, m_v, m_c, m_a0, m_busy, m_resp, m_taken;
  logic [4:0] m_cond;
  logic [15:0] m_target;

  cond_branch_sequencer #(.PEND_W(2), .TGT_W(16)) dut (
    .clk(clk), .rst(rst), .flag_issue(flag_issue), .flag_issue_ready(flag_issue_ready),
    .alu_done(alu_done), .alu_setflags(alu_setflags), .alu_sel_sum(alu_sel_sum),
    .alu_zero(alu_zero), .alu_msb(alu_msb), .alu_carry(alu_carry),
    .a_msb(a_msb), .b_msb(b_msb), .a_lsb(a_lsb),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_target(br_target),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken), .res_target(res_target),
    .flush(flush)
  );

  always #5 clk = ~clk;

  function automatic bit cond_true(logic [4:0] c, bit z, bit n, bit v, bit cf, bit a0);
    bit b;
    case (c[3:0])
      4'd0: b = 1;
      4'd1: b = z;
      4'd2: b = n;
      4'd3: b = v;
      4'd4: b = cf;
      4'd5: b = n ^ v;
      4'd6: b = z | (n ^ v);
      4'd7: b = !cf | z;
      4'd8: b = a0;
      default: b = 0;
    endcase
    return b ^ c[4];
  endfunction

  // Model: a request becomes answerable two cycles after a cycle that sees zero writers pending.
  always @(posedge clk) begin
    bit ret, dec, inc;
    if (rst) begin
      m_cnt = 0; m_due = -1; {m_z, m_n, m_v, m_c, m_a0} = '0;
      m_busy = 0; m_resp = 0; m_taken = 0; m_target = 0; m_cond = 0;
    end else begin
      if (flush) begin
        m_busy = 0; m_resp = 0;
      end else if (m_resp) begin
        if (res_ready) begin m_busy = 0; m_resp = 0; end
      end else if (m_busy) begin
        if (m_due == cyc + 1) begin m_resp = 1; m_taken = cond_true(m_cond, m_z, m_n, m_v, m_c, m_a0); end
        else if (m_due < 0 && m_cnt == 0) m_due = cyc + 2;
      end else if (br_valid) begin
        m_busy = 1; m_cond = br_cond; m_target = br_target;
        m_due = (m_cnt == 0) ? cyc + 2 : -1;
      end
      ret = alu_done && alu_setflags;
      dec = ret && m_cnt > 0;
      inc = flag_issue && (m_cnt < MAXC || dec);
      m_cnt = m_cnt + int'(inc) - int'(dec);
      if (ret) begin
        m_z = alu_zero; m_n = alu_msb; m_c = alu_carry; m_a0 = a_lsb;
        m_v = alu_sel_sum && (a_msb == b_msb) && (alu_msb != a_msb);
      end
    end
    cyc++;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) if (armed) begin
    chk("br_ready", br_ready, m_busy ? 0 : 1);
    chk("flag_issue_ready", flag_issue_ready, (m_cnt != MAXC) ? 1 : 0);
    chk("res_valid", res_valid, m_resp);
    if (m_resp) begin
      chk("res_taken", res_taken, m_taken);
      chk("res_target", res_target, m_target);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_resp();
    int n = 0;
    while (res_valid !== 1'b1 && n < 50) begin step(); n++; end
    chk("resp_timeout", res_valid, 1);
  endtask

  task automatic branch(logic [4:0] c, logic [15:0] t);
    br_valid = 1; br_cond = c; br_target = t;
    step();
    br_valid = 0;
    wait_resp();
  endtask

  task automatic ack();
    res_ready = 1; step(); res_ready = 0;
  endtask

  task automatic retire(bit z);
    alu_done = 1; alu_setflags = 1; alu_zero = z;
    step();
    alu_done = 0; alu_setflags = 0; alu_zero = 0;
  endtask

  initial begin
    step(); step();
    rst = 0; armed = 1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_taken", res_taken, 0);
    chk("rst_res_target", res_target, 0);
    chk("rst_br_ready", br_ready, 1);
    chk("rst_fir", flag_issue_ready, 1);
    // Immediate branch on Z with no flags loaded.
    br_valid = 1; br_cond = 5'h01; br_target = 16'hABCD;
    step();
    br_valid = 0;
    chk("t1_not_yet", res_valid, 0);
    step();
    chk("t1_valid_T2", res_valid, 1);
    chk("t1_taken", res_taken, 0);
    chk("t1_target", res_target, 16'hABCD);
    ack();
    // Signed overflow: 0 + 0 -> negative.
    alu_done = 1; alu_setflags = 1; alu_sel_sum = 1; alu_msb = 1;
    step();
    alu_done = 0; alu_setflags = 0; alu_sel_sum = 0; alu_msb = 0;
    branch(5'h03, 16'h0003);
    chk("t2_v_taken", res_taken, 1);
    ack();
    branch(5'h05, 16'h0005);
    chk("t2_nxorv_taken", res_taken, 0);
    ack();
    // Two pending writers; the second retire sets Z.
    flag_issue = 1; step(); step(); flag_issue = 0;
    br_valid = 1; br_cond = 5'h01; br_target = 16'h0101; step(); br_valid = 0;
    step(); step();
    retire(0);
    step(); step();
    retire(1);
    chk("t3_wait", res_valid, 0);
    step();
    chk("t3_wait_eval", res_valid, 0);
    step();
    chk("t3_valid_R3", res_valid, 1);
    chk("t3_taken", res_taken, 1);
    ack();
    // Counter boundaries.
    flag_issue = 1; step(); step(); step();
    chk("t4_full", flag_issue_ready, 0);
    step();
    chk("t4_drop", flag_issue_ready, 0);
    alu_done = 1; alu_setflags = 1; step();
    chk("t4_both_at_max", flag_issue_ready, 0);
    flag_issue = 0; step(); step(); step();
    chk("t4_empty", flag_issue_ready, 1);
    step();
    alu_done = 0; alu_setflags = 0;
    chk("t4_no_wrap", flag_issue_ready, 1);
    flag_issue = 1; step(); step();
    chk("t4_two", flag_issue_ready, 1);
    step();
    chk("t4_three", flag_issue_ready, 0);
    flag_issue = 0;
    retire(0); retire(0); retire(0);
    // Backpressure then flush in RESP.
    branch(5'h00, 16'h1234);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_hold_valid", res_valid, 1);
      chk("t5_hold_taken", res_taken, 1);
      chk("t5_hold_target", res_target, 16'h1234);
    end
    flush = 1; step(); flush = 0;
    chk("t5_flush_valid", res_valid, 0);
    chk("t5_flush_idle", br_ready, 1);
    // Inversion and reserved codes.
    branch(5'h10, 16'h0010);
    chk("t6_inv_always", res_taken, 0);
    ack();
    branch(5'h19, 16'h0019);
    chk("t6_inv_reserved", res_taken, 1);
    ack();
    alu_done = 1; alu_setflags = 1; a_lsb = 1; step();
    alu_done = 0; alu_setflags = 0; a_lsb = 0;
    branch(5'h08, 16'h0008);
    chk("t6_a0", res_taken, 1);
    ack();
    // Reset while waiting on a writer.
    flag_issue = 1; step(); flag_issue = 0;
    br_valid = 1; br_cond = 5'h00; step(); br_valid = 0;
    step();
    chk("t7_waiting", br_ready, 0);
    rst = 1; step(); rst = 0;
    chk("t7_rst_ready", br_ready, 1);
    chk("t7_rst_valid", res_valid, 0);
    chk("t7_rst_fir", flag_issue_ready, 1);
    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      flag_issue = $urandom_range(0, 2) == 0;
      alu_done = $urandom_range(0, 2) == 0;
      alu_setflags = $urandom_range(0, 3) != 0;
      {alu_sel_sum, alu_zero, alu_msb, alu_carry, a_msb, b_msb, a_lsb} = 7'($urandom);
      br_valid = $urandom_range(0, 2) == 0;
      br_cond = 5'($urandom);
      br_target = 16'($urandom);
      res_ready = $urandom_range(0, 1) == 0;
      flush = $urandom_range(0, 40) == 0;
      rst = $urandom_range(0, 400) == 0;
      step();
    end
    {flag_issue, alu_done, alu_setflags, br_valid, res_ready, flush, rst} = '0;
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
